// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: timing defaults, mode register value,
// command encodings and the read-capture FSM state type.
package sdram_pkg;

    localparam int DEF_CAS_LAT   = 3;
    localparam int DEF_BURST_LEN = 1024;

    // CL=3, sequential, full-page burst
    localparam logic [12:0] MODE_REG = 13'h0037;

    // Command encodings as {ras, cas, we} with cs asserted
    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_AUTO = 3'b001;
    localparam logic [2:0] CMD_LMR  = 3'b000;
    localparam logic [2:0] CMD_ACT  = 3'b011;
    localparam logic [2:0] CMD_RD   = 3'b101;
    localparam logic [2:0] CMD_WR   = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CL = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_rd_capture_if.sv
// Read-data output stream: FIFO head data with last-beat marker and valid/ready.
interface sdram_rd_capture_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, m_last, m_valid, input m_ready);
    modport slave  (input m_data, m_last, m_valid, output m_ready);

endinterface

// File: rtl/sdram_rd_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only if a pop happens in the same cycle.
module sdram_rd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal)
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_rd_capture.sv
// SDRAM read-data capture: waits CAS latency after READ, samples DQ for the
// full-page burst (or until a PRECHARGE truncates it) and streams beats out.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CAS_LAT    = DEF_CAS_LAT,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_rd,
    input  logic                 cmd_pre,
    input  logic [DATA_W-1:0]    dq_in,
    sdram_rd_capture_if.master   m,
    output logic                 busy,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic                 ovf_err,
    output logic                 cmd_err
);

    localparam int LAT_W = (CAS_LAT > 1) ? $clog2(CAS_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CAS_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);

    state_t             state, state_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_nxt;
    logic               trunc_arm, tarm_nxt;
    logic [LAT_W-1:0]   trunc_cnt, tcnt_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [LAT_W-1:0]   tr_cnt, tr_dec;
    logic               tr_on;
    logic               push, beat_last, start, err_set;

    logic               pop, drop;
    logic               fifo_full, fifo_empty;
    logic [DATA_W:0]    fifo_dout;

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        tarm_nxt  = trunc_arm;
        tcnt_nxt  = trunc_cnt;
        cnt_nxt   = beat_cnt;
        tr_cnt    = trunc_cnt;
        tr_on     = trunc_arm;
        tr_dec    = '0;
        push      = 1'b0;
        beat_last = 1'b0;
        start     = 1'b0;
        err_set   = 1'b0;

        unique case (state)
            IDLE: begin
                tarm_nxt = 1'b0;
                start    = cmd_rd;
            end
            WAIT_CL: begin
                err_set = cmd_rd;
                // Truncate countdown only ticks on captured beats
                if (cmd_pre && !trunc_arm) begin
                    tarm_nxt = 1'b1;
                    tcnt_nxt = LAT_LOAD;
                end
                lat_nxt = lat_cnt - LAT_W'(1);
                if (lat_cnt == LAT_W'(1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                push = 1'b1;
                if (beat_cnt != CNT_MAX) begin
                    cnt_nxt = beat_cnt + CNT_W'(1);
                end
                // The precharge cycle's own beat counts toward the countdown
                if (!trunc_arm && cmd_pre) begin
                    tr_on  = 1'b1;
                    tr_cnt = LAT_LOAD;
                end
                tr_dec    = tr_cnt - LAT_W'(1);
                tarm_nxt  = tr_on;
                tcnt_nxt  = tr_dec;
                beat_last = (beat_cnt == LAST_IDX) || (tr_on && (tr_dec == '0));
                if (beat_last) begin
                    tarm_nxt  = 1'b0;
                    state_nxt = IDLE;
                    start     = cmd_rd;
                end else begin
                    err_set = cmd_rd;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            cnt_nxt = '0;
            if (CAS_LAT > 1) begin
                state_nxt = WAIT_CL;
                lat_nxt   = LAT_LOAD;
            end else begin
                state_nxt = CAPTURE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            trunc_arm <= 1'b0;
            trunc_cnt <= '0;
            beat_cnt  <= '0;
            ovf_err   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_nxt;
            trunc_arm <= tarm_nxt;
            trunc_cnt <= tcnt_nxt;
            beat_cnt  <= cnt_nxt;
            ovf_err   <= ovf_err | drop;
            cmd_err   <= cmd_err | err_set;
        end
    end

    assign busy = (state != IDLE);
    assign pop  = m.m_valid && m.m_ready;
    assign drop = push && fifo_full && !pop;

    sdram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({beat_last, dq_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m.m_valid = !fifo_empty;
    assign m.m_last  = fifo_dout[DATA_W];
    assign m.m_data  = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Scoreboard bench for sdram_rd_capture: expected beats are queued at command
// issue and a negedge monitor compares every accepted output beat.
module tb_sdram_rd_capture;

    localparam int DATA_W = 16;
    localparam int CL     = 3;
    localparam int BL     = 1024;
    localparam int CNT_W  = 11;

    typedef logic [DATA_W:0] beat_t;

    logic             clk;
    logic             rst;
    logic             cmd_rd;
    logic             cmd_pre;
    logic [DATA_W-1:0] dq_in;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;
    logic             ovf_err;
    logic             cmd_err;

    sdram_rd_capture_if #(.DATA_W(DATA_W)) bus ();

    sdram_rd_capture #(
        .DATA_W     (DATA_W),
        .CAS_LAT    (CL),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (16),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_rd   (cmd_rd),
        .cmd_pre  (cmd_pre),
        .dq_in    (dq_in),
        .m        (bus.master),
        .busy     (busy),
        .beat_cnt (beat_cnt),
        .ovf_err  (ovf_err),
        .cmd_err  (cmd_err)
    );

    int    nvec  = 0;
    int    nfail = 0;
    int    cyc   = 0;
    beat_t exp_q[$];
    logic  rnd_en    = 1'b0;
    logic  rdy_fixed = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DQ carries the cycle number, so beat j of a READ issued in cycle c0 is c0+CL+j
    always @(posedge clk) begin
        #2;
        dq_in = 16'(cyc);
    end

    always @(posedge clk) begin
        #1;
        bus.m_ready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL beat: unexpected output last=%0b data=%0d, none expected",
                         bus.m_last, bus.m_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({bus.m_last, bus.m_data} !== e) begin
                    nfail++;
                    $display("FAIL beat: got last=%0b data=%0d expected last=%0b data=%0d",
                             bus.m_last, bus.m_data, e[DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_rd();
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
    endtask

    task automatic pulse_pre();
        cmd_pre = 1'b1;
        tick();
        cmd_pre = 1'b0;
    endtask

    // Queue the expected stored beats, then pulse READ; c0 is the command cycle
    task automatic issue_rd(input int nbeats, input int nstore, output int c0);
        c0 = cyc;
        for (int j = 0; j < nstore; j++) begin
            exp_q.push_back({(j == nbeats - 1), 16'(c0 + CL + j)});
        end
        pulse_rd();
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        @(negedge clk);
        check({name, " drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int c1;
        rst     = 1'b1;
        cmd_rd  = 1'b0;
        cmd_pre = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst m_valid", {31'd0, bus.m_valid}, 0);
        check("rst m_data", {16'd0, bus.m_data}, 0);
        check("rst m_last", {31'd0, bus.m_last}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst beat_cnt", {21'd0, beat_cnt}, 0);
        check("rst ovf_err", {31'd0, ovf_err}, 0);
        check("rst cmd_err", {31'd0, cmd_err}, 0);

        // Full burst, consumer always ready
        tick_to(10);
        issue_rd(BL, BL, c0);
        @(negedge clk);
        check("full busy", {31'd0, busy}, 1);
        tick_to(c0 + 3);
        @(negedge clk);
        check("full no early valid", {31'd0, bus.m_valid}, 0);
        tick();
        @(negedge clk);
        check("full first valid", {31'd0, bus.m_valid}, 1);
        wait_idle("full", 1100);
        check("full beat_cnt", {21'd0, beat_cnt}, BL);
        wait_drain("full", 100);

        // Precharge on capture beat 100
        issue_rd(102, 102, c0);
        tick_to(c0 + CL + 100);
        pulse_pre();
        wait_idle("trunc", 50);
        check("trunc beat_cnt", {21'd0, beat_cnt}, 102);
        wait_drain("trunc", 100);

        // Overflow: consumer stalled for the whole burst
        rdy_fixed = 1'b0;
        tick();
        tick();
        issue_rd(BL, 16, c0);
        tick_to(c0 + CL + 16);
        @(negedge clk);
        check("ovf before drop", {31'd0, ovf_err}, 0);
        tick();
        @(negedge clk);
        check("ovf after drop", {31'd0, ovf_err}, 1);
        wait_idle("ovf", 1100);
        check("ovf beat_cnt", {21'd0, beat_cnt}, BL);
        check("ovf held valid", {31'd0, bus.m_valid}, 1);
        rdy_fixed = 1'b1;
        wait_drain("ovf", 100);
        tick();
        tick();
        @(negedge clk);
        check("ovf empty after 16", {31'd0, bus.m_valid}, 0);
        do_reset();
        @(negedge clk);
        check("ovf cleared by rst", {31'd0, ovf_err}, 0);

        // Random back-pressure, burst truncated to 8 beats
        rnd_en = 1'b1;
        issue_rd(8, 8, c0);
        tick_to(c0 + CL + 6);
        pulse_pre();
        wait_idle("bp", 50);
        check("bp beat_cnt", {21'd0, beat_cnt}, 8);
        wait_drain("bp", 200);
        check("bp ovf_err", {31'd0, ovf_err}, 0);
        rnd_en = 1'b0;
        tick();

        // Illegal READs mid-burst, then a legal READ on the last-beat cycle
        issue_rd(BL, BL, c0);
        pulse_rd();
        @(negedge clk);
        check("illegal cmd_err", {31'd0, cmd_err}, 1);
        tick_to(c0 + CL + 500);
        pulse_rd();
        @(negedge clk);
        check("illegal still busy", {31'd0, busy}, 1);
        tick_to(c0 + CL + BL - 1);
        issue_rd(5, 5, c1);
        @(negedge clk);
        check("chain busy", {31'd0, busy}, 1);
        check("chain beat_cnt clr", {21'd0, beat_cnt}, 0);
        tick_to(c1 + CL + 3);
        pulse_pre();
        wait_idle("chain", 50);
        check("chain beat_cnt", {21'd0, beat_cnt}, 5);
        wait_drain("chain", 100);

        // Synchronous reset at capture beat 500
        issue_rd(BL, BL, c0);
        tick_to(c0 + CL + 500);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid m_valid", {31'd0, bus.m_valid}, 0);
        check("rstmid beat_cnt", {21'd0, beat_cnt}, 0);
        check("rstmid busy", {31'd0, busy}, 0);
        check("rstmid cmd_err", {31'd0, cmd_err}, 0);
        check("rstmid ovf_err", {31'd0, ovf_err}, 0);
        tick();
        @(negedge clk);
        check("rstmid no push", {31'd0, bus.m_valid}, 0);
        issue_rd(BL, BL, c0);
        wait_idle("post rst", 1100);
        check("post rst beat_cnt", {21'd0, beat_cnt}, BL);
        wait_drain("post rst", 100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
